// File: rtl/scratchpad_stream_reader_pkg.sv
// Shared scratchpad package: default word/address widths
// and the stream reader FSM state encoding.
package scratchpad_stream_reader_pkg;

  localparam int SP_DATA_WIDTH = 32;
  localparam int SP_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/scratchpad_stream_reader_if.sv
// Output word stream: m_valid/m_data/m_last from master,
// m_ready from slave.
interface scratchpad_stream_reader_if
  import scratchpad_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = SP_DATA_WIDTH
) ();

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/scratchpad_stream_reader_fifo.sv
// sync_fifo: single-clock FIFO; ports push/wdata, pop/rdata,
// empty and occupancy count. rdata reads 0 while empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != FULL_C);
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scratchpad_stream_reader.sv
// Streams length words from the scratchpad starting at base_addr;
// ports: start/base_addr/length cmd, busy/done, re_b/addr_b/rdata_b, m stream.
module scratchpad_stream_reader
  import scratchpad_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = SP_DATA_WIDTH,
  parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  re_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] rdata_b,
  scratchpad_stream_reader_if.master m
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C = (ADDR_WIDTH + 1)'(1);

  rd_state_e state_q;
  rd_state_e state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   left_q;
  logic                  inflight_q;
  logic                  infl_last_q;
  logic                  done_q;

  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  pop;
  logic                  last_pop;
  logic                  issue;
  logic                  final_rd;
  logic                  accept;
  logic                  zero_cmd;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .wdata ({infl_last_q, rdata_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (count)
  );

  assign m.m_valid = !fifo_empty;
  assign m.m_data  = fifo_rdata[DATA_WIDTH-1:0];
  assign m.m_last  = fifo_rdata[DATA_WIDTH];

  assign pop      = m.m_valid && m.m_ready;
  assign last_pop = pop && m.m_last;
  assign final_rd = (left_q == ONE_C);

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign re_b   = issue;
  assign addr_b = addr_q;

  // Credit: words buffered plus the read whose data lands next cycle.
  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    accept   = 1'b0;
    zero_cmd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept  = 1'b1;
            state_d = READ;
          end else begin
            zero_cmd = 1'b1;
          end
        end
      end
      READ: begin
        issue = (occ < DEPTH_C);
        if (issue && final_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      left_q      <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= zero_cmd || last_pop;
      inflight_q  <= issue;
      infl_last_q <= issue && final_rd;
      if (accept) begin
        addr_q <= base_addr;
        left_q <= length;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        left_q <= left_q - ONE_C;
      end
    end
  end

endmodule
